mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that responds to the pipelined core's data-memory bus (M-stage address, write data, write enable, read data) alongside the data memory. Stores written bytes in a small FIFO and serialises them as 8N1 frames on a single output line. Register reads are combinational, like the data memory. Writes take effect on the rising clock edge. The top level uses `hit` to mux `rd` against the data memory's read data.

---
 rtl/mmio_uart_tx.sv | 191 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the M-stage data bus.
// A small TX FIFO feeds a START/DATA/STOP serialiser paced by a per-frame latched divisor.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [31:0] i_a,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd,
  output logic        o_hit,
  output logic        o_tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [15:0]   r_div;
  logic [15:0]   r_div_lat;
  logic [15:0]   r_timer;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic          w_hit;
  logic [1:0]    w_off;
  logic          w_wr;
  logic          w_full;
  logic          w_empty;
  logic          w_busy;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_bit_end;
  logic [31:0]   w_rd;
  logic          w_unused;

  assign w_hit     = (i_a[31:4] == BASE_ADDR[31:4]);
  assign w_off     = i_a[3:2];
  assign w_wr      = i_we & w_hit;
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == {CW{1'b0}});
  assign w_busy    = (r_state != S_IDLE);
  assign w_bit_end = (r_timer == 16'd0);
  // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a push.
  assign w_push    = w_wr & (w_off == 2'd0) & ~w_full;
  assign w_drop    = w_wr & (w_off == 2'd0) & w_full;
  assign w_pop     = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
  assign w_unused  = ^{i_a[1:0], i_wd[31:16]};

  // Combinational register read mux; zero outside the window.
  always_comb begin
    w_rd = 32'd0;
    if (w_hit) begin
      case (w_off)
        2'd1:    w_rd = {23'd0, r_ovf, 5'(r_count), w_empty, w_full, w_busy};
        2'd2:    w_rd = {16'd0, r_div};
        default: w_rd = 32'd0;
      endcase
    end else begin
      w_rd = 32'd0;
    end
  end

  assign o_rd  = w_rd;
  assign o_hit = w_hit;
  assign o_tx  = r_tx;

  // FIFO storage; not reset since the pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wd[7:0];
    end
  end

  // FIFO pointers, occupancy, overflow flag and divisor register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
      r_ovf   <= 1'b0;
      r_div   <= 16'(CLKS_PER_BIT);
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_off == 2'd1) && i_wd[8]) begin
        r_ovf <= 1'b0;
      end
      if (w_wr && (w_off == 2'd2)) begin
        r_div <= (i_wd[15:0] == 16'd0) ? 16'd1 : i_wd[15:0];
      end
    end
  end

  // Serialiser FSM; every frame start latches the divisor so mid-frame writes only affect later frames.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_div_lat <= 16'd1;
      r_timer   <= 16'd0;
      r_bitcnt  <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift   <= r_mem[r_rptr];
            r_div_lat <= r_div;
            r_timer   <= r_div - 16'd1;
            r_state   <= S_START;
            r_tx      <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state  <= S_DATA;
            r_timer  <= r_div_lat - 16'd1;
            r_bitcnt <= 3'd0;
            r_tx     <= r_shift[0];
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_timer <= r_div_lat - 16'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift  <= {1'b0, r_shift[7:1]};
              r_tx     <= r_shift[1];
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift   <= r_mem[r_rptr];
              r_div_lat <= r_div;
              r_timer   <= r_div - 16'd1;
              r_state   <= S_START;
              r_tx      <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a serial monitor checks every frame bit-by-cycle
// against a scoreboard of (byte, divisor) pushed when each TXDATA store is issued.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        hit;
  logic        tx;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        mon_en;
  logic [7:0]  exp_data_q [$];
  int          exp_d_q [$];
  int          starts [$];

  mmio_uart_tx dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_we    (we),
    .i_a     (a),
    .i_wd    (wd),
    .o_rd    (rd),
    .o_hit   (hit),
    .o_tx    (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    a  = addr;
    wd = data;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    we = 1'b0;
    a  = addr;
    #1;
    data = rd;
  endtask

  task automatic send(input logic [7:0] b, input int d);
    exp_data_q.push_back(b);
    exp_d_q.push_back(d);
    bus_write(BASE, {24'd0, b});
  endtask

  task automatic wait_idle(input int budget, output int busy_cycles);
    logic [31:0] s;
    busy_cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      bus_read(BASE + 32'd4, s);
      if (s[0] == 1'b0 && s[2] == 1'b1) return;
      busy_cycles++;
    end
    n_vec++;
    n_err++;
    $error("FAIL wait_idle: observed busy after %0d cycles expected idle", budget);
  endtask

  // Serial monitor: every cycle of a frame must match start/data/stop at the scoreboard divisor.
  initial begin : monitor
    logic [9:0] fr;
    logic [7:0] b;
    logic       bad;
    logic       obs;
    int         d;
    int         fidx;
    fidx = 0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin
        starts.push_back(cyc);
        n_vec++;
        assert (exp_data_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_frame: observed start bit at cycle %0d expected none", cyc);
        end
        if (exp_data_q.size() == 0) begin
          while (tx === 1'b0) @(negedge clk);
        end else begin
          b  = exp_data_q.pop_front();
          d  = exp_d_q.pop_front();
          fr = {1'b1, b, 1'b0};
          for (int bit_i = 0; bit_i < 10; bit_i++) begin
            bad = 1'b0;
            obs = fr[bit_i];
            for (int k = 0; k < d; k++) begin
              if (bit_i != 0 || k != 0) @(negedge clk);
              if (tx !== fr[bit_i]) begin
                bad = 1'b1;
                obs = tx;
              end
            end
            check($sformatf("frame%0d_byte%02h_bit%0d", fidx, b, bit_i),
                  {31'd0, obs}, {31'd0, fr[bit_i]});
          end
          fidx++;
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] s;
    int          bc;

    rst_n  = 1'b0;
    we     = 1'b0;
    a      = BASE + 32'd4;
    wd     = 32'd0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_tx", {31'd0, tx}, 32'd1);
    bus_read(BASE + 32'd4, s);
    check("rst_status", s, 32'h0000_0004);
    check("rst_hit", {31'd0, hit}, 32'd1);
    bus_read(BASE + 32'd8, s);
    check("rst_divisor", s, 32'd16);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 0xA5 frame at D=4.
    bus_write(BASE + 32'd8, 32'd4);
    send(8'hA5, 4);
    bus_read(BASE + 32'd4, s);
    check("a5_status_before_pop", s, 32'h0000_0008);
    @(negedge clk);
    bus_read(BASE + 32'd4, s);
    check("a5_status_after_pop", s, 32'h0000_0005);
    wait_idle(200, bc);
    check("a5_busy_cycles", bc, 32'd39);
    bus_read(BASE + 32'd4, s);
    check("a5_status_end", s, 32'h0000_0004);
    check("a5_sb_drained", exp_data_q.size(), 32'd0);

    // Three back-to-back frames at D=2.
    bus_write(BASE + 32'd8, 32'd2);
    starts.delete();
    send(8'h01, 2);
    send(8'h02, 2);
    send(8'h03, 2);
    bus_read(BASE + 32'd4, s);
    check("b2b_count", {27'd0, s[7:3]}, 32'd2);
    wait_idle(300, bc);
    check("b2b_frames", starts.size(), 32'd3);
    if (starts.size() == 3) begin
      check("b2b_gap01", starts[1] - starts[0], 32'd20);
      check("b2b_gap12", starts[2] - starts[1], 32'd20);
    end
    check("b2b_sb_drained", exp_data_q.size(), 32'd0);

    // Overflow while mid-frame; fifth queued byte must be dropped.
    bus_write(BASE + 32'd8, 32'd4);
    send(8'h31, 4);
    repeat (2) @(negedge clk);
    send(8'h41, 4);
    send(8'h42, 4);
    send(8'h43, 4);
    send(8'h44, 4);
    bus_write(BASE, 32'h0000_0045);
    bus_read(BASE + 32'd4, s);
    check("ovf_status_full", s, 32'h0000_0123);
    bus_write(BASE + 32'd4, 32'h0000_00FF);
    bus_read(BASE + 32'd4, s);
    check("ovf_not_cleared", s, 32'h0000_0123);
    bus_write(BASE + 32'd4, 32'h0000_0100);
    bus_read(BASE + 32'd4, s);
    check("ovf_cleared", s, 32'h0000_0023);
    wait_idle(600, bc);
    bus_read(BASE + 32'd4, s);
    check("ovf_status_end", s, 32'h0000_0004);
    check("ovf_sb_drained", exp_data_q.size(), 32'd0);

    // Divisor change mid-frame only affects the next frame.
    starts.delete();
    send(8'h11, 4);
    send(8'h22, 8);
    bus_write(BASE + 32'd8, 32'd8);
    bus_read(BASE + 32'd8, s);
    check("div_readback8", s, 32'd8);
    wait_idle(400, bc);
    check("div_frames", starts.size(), 32'd2);
    if (starts.size() == 2) begin
      check("div_first_len", starts[1] - starts[0], 32'd40);
    end
    check("div_sb_drained", exp_data_q.size(), 32'd0);

    // Out-of-window accesses and register map corners.
    bus_write(BASE + 32'd16, 32'h0000_0077);
    bus_write(BASE - 32'd4, 32'h0000_0066);
    bus_write(BASE + 32'h18, 32'd3);
    bus_read(BASE + 32'd16, s);
    check("oow_hi_rd", s, 32'd0);
    check("oow_hi_hit", {31'd0, hit}, 32'd0);
    bus_read(BASE - 32'd4, s);
    check("oow_lo_rd", s, 32'd0);
    check("oow_lo_hit", {31'd0, hit}, 32'd0);
    bus_read(BASE + 32'h14, s);
    check("oow_status_alias_rd", s, 32'd0);
    repeat (3) @(negedge clk);
    bus_read(BASE + 32'd4, s);
    check("oow_no_push", s, 32'h0000_0004);
    bus_read(BASE + 32'd8, s);
    check("oow_div_unchanged", s, 32'd8);
    bus_write(BASE + 32'd12, 32'hFFFF_FFFF);
    bus_read(BASE + 32'd12, s);
    check("reserved_rd", s, 32'd0);
    check("reserved_hit", {31'd0, hit}, 32'd1);
    bus_read(BASE, s);
    check("txdata_rd", s, 32'd0);
    bus_read(BASE + 32'd5, s);
    check("status_byte_offset", s, 32'h0000_0004);
    bus_write(BASE + 32'd8, 32'd0);
    bus_read(BASE + 32'd8, s);
    check("div_zero_as_one", s, 32'd1);
    bus_write(BASE + 32'h0A, 32'hABCD_0006);
    bus_read(BASE + 32'd8, s);
    check("div_upper_ignored", s, 32'd6);

    // Reset during the DATA phase of a 0x00 frame with another byte queued.
    bus_write(BASE + 32'd8, 32'd4);
    mon_en = 1'b0;
    bus_write(BASE, 32'h0000_0000);
    bus_write(BASE, 32'h0000_005A);
    repeat (8) @(negedge clk);
    check("mid_data_tx_low", {31'd0, tx}, 32'd0);
    bus_read(BASE + 32'd4, s);
    check("mid_data_busy", {31'd0, s[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    bus_read(BASE + 32'd4, s);
    check("async_rst_status", s, 32'h0000_0004);
    bus_read(BASE + 32'd8, s);
    check("async_rst_div", s, 32'd16);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("post_rst_tx_idle", {31'd0, tx}, 32'd1);
    bus_read(BASE + 32'd4, s);
    check("post_rst_status", s, 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
